// File: rtl/seg7_cmd_ctrl.sv
// seg7_cmd_ctrl
// Turns framed SPI byte streams into display commands for a 4-digit 7-segment
// interface. Multi-byte commands are staged in shadow registers and committed
// atomically on the edge that samples their final byte. A local BCD up-counter
// mode, advanced by an external tick, shares the digit registers with host writes.
//
// Optional build macro: SEG7_READBACK_EN
//   defined   -> tx_data = registered {cmd_err, mode, colon, fsm_state[3:0]}
//   undefined -> tx_data tied to 8'h00, FSM encoding not exported
module seg7_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       cs_n,
    input  logic       tick,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic       mode,
    output logic       frame_done,
    output logic       cmd_err,
    output logic [7:0] tx_data
);

    // Encoding is 4 bits wide so it can be exported verbatim on tx_data.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_OPCODE  = 4'd1,
        ST_ARG     = 4'd2,
        ST_DISCARD = 4'd3
    } state_t;

    localparam logic [7:0] OP_WRITE_DIGITS = 8'h01;
    localparam logic [7:0] OP_SET_COLON    = 8'h02;
    localparam logic [7:0] OP_SET_MODE     = 8'h03;
    localparam logic [7:0] OP_CLEAR        = 8'h04;

    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]           COLON_OFF = 2'b11;

    state_t               state_q;
    state_t               state_d;
    logic                 cs_n_q;
    logic [7:0]           op_q;        // shadow: opcode of the command in flight
    logic [7:0]           arg0_q;      // shadow: first argument of WRITE_DIGITS
    logic                 arg_idx_q;   // 0 = next byte is arg0, 1 = next byte is arg1
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [15:0]          disp_q;      // {digit3, digit2, digit1, digit0}

    logic frame_start;
    logic byte_strobe;
    logic tmo_hit;
    logic op_known;
    logic last_arg;
    logic op_load;
    logic arg_load;
    logic commit_clear;
    logic commit_arg;
    logic err_set;
    logic err_clr;

    assign frame_start = cs_n_q & ~cs_n;
    assign byte_strobe = rx_valid & ~cs_n;   // bytes outside a frame never reach the parser
    assign tmo_hit     = (tmo_cnt == TMO_LIMIT);
    assign op_known    = rx_data inside {OP_WRITE_DIGITS, OP_SET_COLON, OP_SET_MODE, OP_CLEAR};
    assign last_arg    = (op_q != OP_WRITE_DIGITS) | arg_idx_q;

    assign digit0 = disp_q[3:0];
    assign digit1 = disp_q[7:4];
    assign digit2 = disp_q[11:8];
    assign digit3 = disp_q[15:12];

    // Four-digit decimal increment; a nibble above 9 behaves as 9 (wraps and carries).
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: frame boundaries, opcode decode, argument counting, timeout.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_OPCODE;
            end
            ST_OPCODE: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (byte_strobe) begin
                    if (!op_known)                 state_d = ST_DISCARD;
                    else if (rx_data != OP_CLEAR)  state_d = ST_ARG;
                end
            end
            ST_ARG: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (byte_strobe) begin
                    if (last_arg) state_d = ST_OPCODE;
                end else if (tmo_hit) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (cs_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode: shadow loads, commits and error set/clear strobes.
    always_comb begin
        op_load      = 1'b0;
        arg_load     = 1'b0;
        commit_clear = 1'b0;
        commit_arg   = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                err_clr = frame_start;
            end
            ST_OPCODE: begin
                if (byte_strobe) begin
                    if (!op_known)                err_set      = 1'b1;
                    else if (rx_data == OP_CLEAR) commit_clear = 1'b1;
                    else                          op_load      = 1'b1;
                end
            end
            ST_ARG: begin
                // Frame closed or timed out with arguments still owed: drop the command.
                if (cs_n) begin
                    err_set = 1'b1;
                end else if (byte_strobe) begin
                    if (last_arg) commit_arg = 1'b1;
                    else          arg_load   = 1'b1;
                end else if (tmo_hit) begin
                    err_set = 1'b1;
                end
            end
            ST_DISCARD: begin
            end
            default: begin
            end
        endcase
    end

    // Frame-select history for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cs_n_q <= 1'b1;
        else     cs_n_q <= cs_n;
    end

    // Shadow registers holding the command being assembled.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: shadows are reset so a stale partial command can never leak into
        // a commit after reset; they are few flops, not a memory array.
        if (rst) begin
            op_q      <= 8'h00;
            arg0_q    <= 8'h00;
            arg_idx_q <= 1'b0;
        end else if (op_load) begin
            op_q      <= rx_data;
            arg_idx_q <= 1'b0;
        end else if (arg_load) begin
            arg0_q    <= rx_data;
            arg_idx_q <= 1'b1;
        end
    end

    // Inter-byte timeout counter: restarts on each byte and at frame start, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_IDLE || frame_start || byte_strobe) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Display registers: host commits take priority over the counter tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= 16'h0000;
            colon  <= COLON_OFF;
            mode   <= 1'b0;
        end else if (commit_clear) begin
            disp_q <= 16'h0000;
            colon  <= COLON_OFF;
        end else if (commit_arg) begin
            unique case (op_q)
                OP_WRITE_DIGITS: disp_q <= {arg0_q, rx_data};
                OP_SET_COLON:    colon  <= rx_data[1:0];
                OP_SET_MODE:     mode   <= rx_data[0];
                default: begin
                end
            endcase
        end else if (tick && mode) begin
            disp_q <= bcd_inc(disp_q);
        end
    end

    // Commit pulse and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            frame_done <= commit_clear | commit_arg;
            if (err_set)      cmd_err <= 1'b1;
            else if (err_clr) cmd_err <= 1'b0;
        end
    end

`ifdef SEG7_READBACK_EN
    // Status byte, refreshed every cycle for shifting out on the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_data <= 8'h00;
        else     tx_data <= {cmd_err, mode, colon, state_q};
    end
`else
    assign tx_data = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_cmd_ctrl.sv
// tb_seg7_cmd_ctrl
// Scoreboard bench: a byte-level command model pushes the expected display on
// every command it completes; a monitor pops and compares on each frame_done.
module tb_seg7_cmd_ctrl;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       cs_n;
    logic       tick;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic       mode;
    logic       frame_done;
    logic       cmd_err;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    seg7_cmd_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cs_n      (cs_n),
        .tick      (tick),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .colon     (colon),
        .mode      (mode),
        .frame_done(frame_done),
        .cmd_err   (cmd_err),
        .tx_data   (tx_data)
    );

    typedef struct packed {
        logic [15:0] digs;
        logic [1:0]  colon;
        logic        mode;
    } disp_t;

    disp_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model state
    logic [3:0] m_dig [4];
    logic [1:0] m_colon;
    logic       m_mode;
    logic       m_err;
    logic       m_discard;
    logic [7:0] m_pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_digs();
        return {digit3, digit2, digit1, digit0};
    endfunction

    function automatic logic [15:0] m_digs();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    endfunction

    function automatic int arg_count(input logic [7:0] op);
        case (op)
            8'h01:   return 2;
            8'h02:   return 1;
            8'h03:   return 1;
            8'h04:   return 0;
            default: return -1;
        endcase
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
        m_colon   = 2'b11;
        m_mode    = 1'b0;
        m_err     = 1'b0;
        m_discard = 1'b0;
        m_pend.delete();
    endfunction

    // Decimal increment: trailing digits at 9 or above roll to 0, the next one steps.
    function automatic void m_tick();
        int k;
        if (!m_mode) return;
        k = 0;
        while (k < 4 && m_dig[k] >= 4'd9) begin
            m_dig[k] = 4'd0;
            k++;
        end
        if (k < 4) m_dig[k] = m_dig[k] + 4'd1;
    endfunction

    function automatic void m_frame_start();
        m_err     = 1'b0;
        m_discard = 1'b0;
        m_pend.delete();
    endfunction

    function automatic void m_frame_end();
        if (m_pend.size() > 0) m_err = 1'b1;
        m_pend.delete();
        m_discard = 1'b0;
    endfunction

    function automatic void m_timeout();
        if (m_pend.size() > 0) begin
            m_err     = 1'b1;
            m_discard = 1'b1;
            m_pend.delete();
        end
    endfunction

    // Returns 1 when this byte completes a command.
    function automatic bit m_byte(input logic [7:0] b);
        logic [7:0] a0, a1;
        int         n;
        if (m_discard) return 1'b0;
        m_pend.push_back(b);
        n = arg_count(m_pend[0]);
        if (n < 0) begin
            m_err     = 1'b1;
            m_discard = 1'b1;
            m_pend.delete();
            return 1'b0;
        end
        if (m_pend.size() != n + 1) return 1'b0;
        a0 = (n > 0) ? m_pend[1] : 8'h00;
        a1 = (n > 1) ? m_pend[2] : 8'h00;
        case (m_pend[0])
            8'h01: begin
                m_dig[3] = a0[7:4];
                m_dig[2] = a0[3:0];
                m_dig[1] = a1[7:4];
                m_dig[0] = a1[3:0];
            end
            8'h02: m_colon = a0[1:0];
            8'h03: m_mode  = a0[0];
            default: begin
                for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
                m_colon = 2'b11;
            end
        endcase
        exp_q.push_back('{digs: m_digs(), colon: m_colon, mode: m_mode});
        m_pend.delete();
        return 1'b1;
    endfunction

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        @(posedge clk);
        #1;
        m_frame_start();
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        m_frame_end();
        check("cmd_err_at_frame_end", cmd_err, m_err);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_tick = 1'b0);
        bit hit;
        rx_data  = b;
        rx_valid = 1'b1;
        tick     = with_tick;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        tick     = 1'b0;
        hit      = cs_n ? 1'b0 : m_byte(b);
        if (with_tick && !hit) m_tick();
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        m_tick();
        check("tick_digits", dut_digs(), m_digs());
    endtask

    task automatic check_display(input string name);
        check({name, "_digits"}, dut_digs(), m_digs());
        check({name, "_colon"}, colon, m_colon);
        check({name, "_mode"}, mode, m_mode);
    endtask

    // Monitor: every frame_done pulse must match the oldest expected commit.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && frame_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_done_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    disp_t e;
                    e = exp_q.pop_front();
                    check("commit_digits", dut_digs(), e.digs);
                    check("commit_colon", colon, e.colon);
                    check("commit_mode", mode, e.mode);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cs_n     = 1'b1;
        tick     = 1'b0;
        m_reset();
        idle(3);

        check("rst_digits", dut_digs(), 16'h0000);
        check("rst_colon", colon, 2'b11);
        check("rst_mode", mode, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        idle(2);

        // WRITE_DIGITS, visible on the final-strobe edge
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        check("wd_latency", dut_digs(), 16'h1234);
        frame_end();
        idle(2);

        // SET_COLON then CLEAR in one frame
        frame_begin();
        send_byte(8'h02);
        send_byte(8'h01);
        check("colon_set", colon, 2'b01);
        send_byte(8'h04);
        check("clear_digits", dut_digs(), 16'h0000);
        check("clear_colon", colon, 2'b11);
        frame_end();
        idle(2);

        // Aborted WRITE_DIGITS: no change, error, cleared by the next frame start
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        frame_end();
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h56);
        frame_end();
        check("abort_err", cmd_err, 1'b1);
        check("abort_digits", dut_digs(), 16'h1234);
        idle(2);
        frame_begin();
        check("err_cleared", cmd_err, 1'b0);
        frame_end();
        idle(2);

        // Invalid opcode discards the rest of the frame
        frame_begin();
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h99);
        send_byte(8'h99);
        check("badop_err", cmd_err, 1'b1);
        check("badop_digits", dut_digs(), 16'h1234);
        frame_end();
        idle(2);

        // Counter mode rollover and commit-over-tick arbitration
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h99);
        send_byte(8'h98);
        send_byte(8'h03);
        send_byte(8'h01);
        frame_end();
        pulse_tick();
        check("count_9999", dut_digs(), 16'h9999);
        pulse_tick();
        check("count_wrap", dut_digs(), 16'h0000);
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01, 1'b1);
        check("tick_vs_commit", dut_digs(), 16'h0001);
        idle(2);
        check("tick_dropped", dut_digs(), 16'h0001);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h3B);
        frame_end();
        pulse_tick();
        check("nibble_gt9_carry", dut_digs(), 16'h0040);
        frame_begin();
        send_byte(8'h03);
        send_byte(8'h00);
        frame_end();
        pulse_tick();
        check("host_tick_ignored", dut_digs(), 16'h0040);
        idle(2);

        // Inter-byte timeout inside ARG
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h12);
        idle(TMO + 24);
        m_timeout();
        check("tmo_err", cmd_err, 1'b1);
        check("tmo_digits", dut_digs(), 16'h0040);
        send_byte(8'h04);
        check("tmo_discard_digits", dut_digs(), 16'h0040);
        frame_end();
        idle(2);

        // Bytes while cs_n is high are ignored
        send_byte(8'h04);
        idle(2);
        check("cs_high_ignored", dut_digs(), 16'h0040);

        // Gaps shorter than the timeout are tolerated
        frame_begin();
        send_byte(8'h01);
        idle(10);
        send_byte(8'h56);
        idle(12);
        send_byte(8'h78);
        check("slow_write", dut_digs(), 16'h5678);
        frame_end();
        idle(2);

        // Randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            int         ncmd;
            int         nargs;
            int         keep;
            logic [7:0] op;
            ncmd = $urandom_range(1, 3);
            frame_begin();
            for (int c = 0; c < ncmd; c++) begin
                if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(5, 255));
                else                           op = 8'($urandom_range(1, 4));
                nargs = (arg_count(op) < 0) ? $urandom_range(0, 2) : arg_count(op);
                keep  = nargs;
                if (c == ncmd - 1 && nargs > 0 && $urandom_range(0, 4) == 0)
                    keep = $urandom_range(0, nargs - 1);
                send_byte(op);
                for (int a = 0; a < keep; a++) begin
                    idle($urandom_range(0, 4));
                    send_byte(8'($urandom));
                end
                idle($urandom_range(0, 3));
            end
            frame_end();
            idle(2);
            check_display("rand");
`ifdef SEG7_READBACK_EN
            check("rand_tx_status", tx_data[7:4], {m_err, m_mode, m_colon});
`else
            check("rand_tx_zero", tx_data, 8'h00);
`endif
            for (int t = $urandom_range(0, 2); t > 0; t--) pulse_tick();
        end

        // Reset in the middle of a frame
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h12);
        rst  = 1'b1;
        cs_n = 1'b1;
        #1;
        m_reset();
        check_display("midrst");
        check("midrst_err", cmd_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        check("midrst_hold", dut_digs(), 16'h0000);

        idle(3);
        check("pending_commits", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
